jpeg_ls_dec_recon: RTL

//   Decoder-side pixel reconstruction for the JPEG-LS path. Takes one signed

---
 rtl/jpeg_ls_dec_recon.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jpeg_ls_dec_recon.sv
// JPEG-LS decoder pixel reconstruction: MED prediction from a one-line causal
// context, then Rx = Px + residual with modulo-RANGE wrap, one pixel per clock.
module jpeg_ls_dec_recon #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BPP    = 16,
    parameter int MAXVAL = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sof,
    input  logic [BPP:0]   errval,
    input  logic           err_en,
    output logic [BPP-1:0] pixel_out,
    output logic [BPP-1:0] Px,
    output logic           out_en,
    output logic           eol,
    output logic           eof
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = BPP + 2;
    localparam logic signed [SW-1:0] MAXV_S  = SW'(MAXVAL);
    localparam logic signed [SW-1:0] RANGE_S = SW'(MAXVAL + 1);
    localparam logic [BPP-1:0]       MAXV_U  = BPP'(MAXVAL);

    typedef struct packed {
        logic [BPP-1:0] ra;
        logic [BPP-1:0] rb;
        logic [BPP-1:0] rc;
    } ctx_t;

    logic [CW-1:0]  col_q, cur_col, nxt_col;
    logic [RW-1:0]  row_q, cur_row, nxt_row;
    logic           last_col, last_row, first_row;
    logic [BPP-1:0] ra_q, rc_q, c0_q, rb_q;
    logic [BPP-1:0] lb [IMG_W];
    ctx_t           ctx;
    logic [BPP-1:0] mx, mn, pred, rx;
    logic signed [SW-1:0] s0, s1;

    // sof overrides the counters so a frame can restart at any time
    always_comb begin
        cur_col   = sof ? '0 : col_q;
        cur_row   = sof ? '0 : row_q;
        last_col  = (cur_col == CW'(IMG_W - 1));
        last_row  = (cur_row == RW'(IMG_H - 1));
        first_row = (cur_row == '0);
        nxt_col   = last_col ? '0 : cur_col + 1'b1;
        nxt_row   = cur_row;
        if (last_col)
            nxt_row = last_row ? '0 : cur_row + 1'b1;
    end

    // rb_q was prefetched on the previous beat; rc_q is the previous beat's Rb,
    // since LB[col-1] already holds the current line by now
    always_comb begin
        ctx.rb = first_row ? '0 : rb_q;
        ctx.ra = (cur_col == '0) ? ctx.rb : ra_q;
        ctx.rc = first_row ? '0 : ((cur_col == '0) ? c0_q : rc_q);
    end

    always_comb begin
        mx   = (ctx.ra > ctx.rb) ? ctx.ra : ctx.rb;
        mn   = (ctx.ra > ctx.rb) ? ctx.rb : ctx.ra;
        // gradient result is always in range, so modulo-2^BPP arithmetic is exact
        pred = ctx.ra + ctx.rb - ctx.rc;
        if (ctx.rc >= mx)
            pred = mn;
        else if (ctx.rc <= mn)
            pred = mx;
    end

    always_comb begin
        s0 = $signed({2'b00, pred}) + $signed({errval[BPP], errval});
        s1 = s0;
        if (s0 < 0)
            s1 = s0 + RANGE_S;
        else if (s0 > MAXV_S)
            s1 = s0 - RANGE_S;
        rx = s1[BPP-1:0];
        if (s1 < 0)
            rx = '0;
        else if (s1 > MAXV_S)
            rx = MAXV_U;
    end

    // Line buffer: no reset, read of next column overlaps write of this one
    always_ff @(posedge clk) begin
        if (err_en) begin
            lb[cur_col] <= rx;
            rb_q        <= lb[nxt_col];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_out <= '0;
            Px        <= '0;
            out_en    <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            ra_q      <= '0;
            rc_q      <= '0;
            c0_q      <= '0;
        end else begin
            out_en <= err_en;
            eol    <= err_en && last_col;
            eof    <= err_en && last_col && last_row;
            if (err_en) begin
                pixel_out <= rx;
                Px        <= pred;
                col_q     <= nxt_col;
                row_q     <= nxt_row;
                ra_q      <= rx;
                rc_q      <= ctx.rb;
                if (cur_col == '0)
                    c0_q <= ctx.ra;
            end
        end
    end
endmodule
